// File: rtl/hazard_ctrl_if.sv
// Hazard sequencer bundle: ID/EX hazard sources in,
// PC / IF-ID / ID-EX pipeline controls out.
interface hazard_ctrl_if #(
  parameter int PERF_W = 16
);
  logic [4:0]        id_rs;
  logic [4:0]        id_rt;
  logic              id_uses_rs;
  logic              id_uses_rt;
  logic              ex_mem_read;
  logic [4:0]        ex_rt;
  logic              id_branch_taken;
  logic              id_mdu_op;
  logic              id_mdu_access;
  logic              imem_ready;
  logic              pc_write;
  logic              if2id_stall;
  logic              if2id_flush;
  logic              id2ex_bubble;
  logic              mdu_busy;
  logic [PERF_W-1:0] stall_cycles;

  modport master (
    output id_rs, id_rt, id_uses_rs, id_uses_rt,
    output ex_mem_read, ex_rt, id_branch_taken,
    output id_mdu_op, id_mdu_access, imem_ready,
    input  pc_write, if2id_stall, if2id_flush,
    input  id2ex_bubble, mdu_busy, stall_cycles
  );

  modport slave (
    input  id_rs, id_rt, id_uses_rs, id_uses_rt,
    input  ex_mem_read, ex_rt, id_branch_taken,
    input  id_mdu_op, id_mdu_access, imem_ready,
    output pc_write, if2id_stall, if2id_flush,
    output id2ex_bubble, mdu_busy, stall_cycles
  );
endinterface

// File: rtl/hazard_ctrl.sv
// Pipeline sequencer: load-use, branch flush, MDU
// occupancy and imem wait-state control.
module hazard_ctrl #(
  parameter int MDU_LATENCY = 32,
  parameter int PERF_W      = 16
) (
  input logic          clk,
  input logic          rst_n,
  hazard_ctrl_if.slave hz
);
  typedef enum logic {RUN, MDU_BUSY} state_t;

  state_t            state_q, state_d;
  logic [5:0]        cnt_q, cnt_d;
  logic [PERF_W-1:0] perf_q;
  logic              lu, mh, ds, busy;
  logic              c_rst, c_ds, c_br, c_nr;
  logic              pc_w, st, fl, bu;

  assign busy = rst_n && (state_q == MDU_BUSY);

  assign lu = hz.ex_mem_read && (hz.ex_rt != 5'd0) &&
              ((hz.id_uses_rs && hz.id_rs == hz.ex_rt) ||
               (hz.id_uses_rt && hz.id_rt == hz.ex_rt));
  assign mh = hz.id_mdu_access && busy;
  assign ds = lu || mh;

  // One-hot priority terms so the decoder below is exclusive
  assign c_rst = !rst_n;
  assign c_ds  = rst_n && ds;
  assign c_br  = rst_n && !ds && hz.id_branch_taken;
  assign c_nr  = rst_n && !ds && !hz.id_branch_taken &&
                 !hz.imem_ready;

  always_comb begin
    pc_w = 1'b1;
    st   = 1'b0;
    fl   = 1'b0;
    bu   = 1'b0;
    unique case (1'b1)
      c_rst: begin
        pc_w = 1'b0;
        fl   = 1'b1;
        bu   = 1'b1;
      end
      c_ds: begin
        pc_w = 1'b0;
        st   = 1'b1;
        bu   = 1'b1;
      end
      c_br: begin
        fl = 1'b1;
      end
      c_nr: begin
        pc_w = 1'b0;
        fl   = 1'b1;
      end
      default: ;
    endcase
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      RUN: begin
        if (hz.id_mdu_op && !ds) begin
          state_d = MDU_BUSY;
          cnt_d   = 6'(MDU_LATENCY);
        end
      end
      MDU_BUSY: begin
        cnt_d = cnt_q - 6'd1;
        if (cnt_q == 6'd1) state_d = RUN;
      end
      default: begin
        state_d = RUN;
        cnt_d   = 6'd0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= RUN;
      cnt_q   <= 6'd0;
      perf_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (!pc_w && perf_q != '1)
        perf_q <= perf_q + 1'b1;
    end
  end

  assign hz.pc_write     = pc_w;
  assign hz.if2id_stall  = st;
  assign hz.if2id_flush  = fl;
  assign hz.id2ex_bubble = bu;
  assign hz.mdu_busy     = busy;
  assign hz.stall_cycles = perf_q;
endmodule

// File: tb/tb_hazard_ctrl.sv
// Randomized + directed bench for hazard_ctrl against
// a cycle-count reference model of the sequencing rules.
module tb_hazard_ctrl;
  localparam int LAT  = 4;
  localparam int PMAX = (1 << 16) - 1;

  logic clk = 1'b0;
  logic rst_n;
  int   n_chk = 0;
  int   n_err = 0;
  int   busy_left = 0;
  int   stalls = 0;

  always #5 clk = ~clk;

  hazard_ctrl_if hz ();

  hazard_ctrl #(
    .MDU_LATENCY(LAT),
    .PERF_W     (16)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .hz   (hz)
  );

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h t=%0t",
               tag, got, exp, $time);
    end
  endtask

  // {pc_write, if2id_stall, if2id_flush, id2ex_bubble, mdu_busy}
  function automatic logic [4:0] exp_ctl();
    logic lu, mh, b;
    if (!rst_n) return 5'b00110;
    b  = busy_left > 0;
    lu = hz.ex_mem_read && hz.ex_rt != 0 &&
         ((hz.id_uses_rs && hz.id_rs == hz.ex_rt) ||
          (hz.id_uses_rt && hz.id_rt == hz.ex_rt));
    mh = hz.id_mdu_access && b;
    if (lu || mh)           return {4'b0101, b};
    if (hz.id_branch_taken) return {4'b1010, b};
    if (!hz.imem_ready)     return {4'b0010, b};
    return {4'b1000, b};
  endfunction

  task automatic cycle();
    logic [4:0] e;
    @(negedge clk);
    e = exp_ctl();
    chk("ctl", 32'({hz.pc_write, hz.if2id_stall,
                    hz.if2id_flush, hz.id2ex_bubble,
                    hz.mdu_busy}), 32'(e));
    chk("perf", 32'(hz.stall_cycles), 32'(stalls));
    chk("excl", 32'(hz.if2id_stall & hz.if2id_flush), 0);
    @(posedge clk);
    if (!rst_n) begin
      busy_left = 0;
      stalls    = 0;
    end else begin
      if (!e[4]) stalls = (stalls < PMAX) ? stalls + 1 : PMAX;
      if (busy_left > 0) busy_left--;
      else if (hz.id_mdu_op && !e[3]) busy_left = LAT;
    end
    #1;
  endtask

  task automatic idle();
    hz.id_rs           = 5'd0;
    hz.id_rt           = 5'd0;
    hz.id_uses_rs      = 1'b0;
    hz.id_uses_rt      = 1'b0;
    hz.ex_mem_read     = 1'b0;
    hz.ex_rt           = 5'd0;
    hz.id_branch_taken = 1'b0;
    hz.id_mdu_op       = 1'b0;
    hz.id_mdu_access   = 1'b0;
    hz.imem_ready      = 1'b1;
  endtask

  task automatic load_use(input logic [4:0] rt);
    hz.ex_mem_read = 1'b1;
    hz.ex_rt       = rt;
    hz.id_rs       = 5'd5;
    hz.id_uses_rs  = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0;
    idle();
    @(posedge clk);
    #1;
    repeat (2) cycle();
    rst_n = 1'b1;
    cycle();

    load_use(5'd5);
    cycle();
    idle();
    cycle();
    load_use(5'd0);
    cycle();
    idle();

    load_use(5'd5);
    hz.id_branch_taken = 1'b1;
    cycle();
    hz.ex_mem_read = 1'b0;
    cycle();
    idle();

    hz.id_mdu_op = 1'b1;
    cycle();
    hz.id_mdu_op     = 1'b0;
    hz.id_mdu_access = 1'b1;
    repeat (5) cycle();
    idle();
    cycle();

    hz.imem_ready = 1'b0;
    repeat (3) cycle();
    hz.id_branch_taken = 1'b1;
    cycle();
    idle();
    cycle();

    hz.id_mdu_op = 1'b1;
    cycle();
    hz.id_mdu_op = 1'b0;
    repeat (2) cycle();
    rst_n = 1'b0;
    cycle();
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_busy", 32'(hz.mdu_busy), 0);
    chk("rst_perf", 32'(hz.stall_cycles), 0);
    @(posedge clk);
    #1;
    cycle();

    for (int i = 0; i < 3000; i++) begin
      hz.id_rs           = 5'($urandom_range(0, 3));
      hz.id_rt           = 5'($urandom_range(0, 3));
      hz.ex_rt           = 5'($urandom_range(0, 3));
      hz.id_uses_rs      = ($urandom_range(0, 1) == 1);
      hz.id_uses_rt      = ($urandom_range(0, 1) == 1);
      hz.ex_mem_read     = ($urandom_range(0, 9) < 3);
      hz.id_branch_taken = ($urandom_range(0, 9) < 2);
      hz.id_mdu_op       = ($urandom_range(0, 9) < 1);
      hz.id_mdu_access   = ($urandom_range(0, 9) < 2);
      hz.imem_ready      = ($urandom_range(0, 9) < 8);
      rst_n              = ($urandom_range(0, 99) != 0);
      cycle();
    end
    rst_n = 1'b1;
    idle();
    repeat (LAT + 2) cycle();

    hz.imem_ready = 1'b0;
    repeat ((1 << 16) + 5) cycle();
    @(negedge clk);
    chk("sat", 32'(hz.stall_cycles), 32'hFFFF);

    $display("Result: errors=%0d of %0d checks",
             n_err, n_chk);
    $finish;
  end
endmodule
